// File: rtl/seg_display_if.sv
// Bus between the top-level controller and the seven-segment display block.
// Signals:
//   mode, text_codes, bin_value, start, lz_blank, blink_en : controller -> display
//   busy, done, overflow, seg                              : display -> controller / HEX pins
// master: the controller side.  slave: the display controller.
interface seg_display_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BIN_WIDTH  = 26
);
    logic [1:0]              mode;
    logic [5*NUM_DIGITS-1:0] text_codes;
    logic [BIN_WIDTH-1:0]    bin_value;
    logic                    start;
    logic                    lz_blank;
    logic                    blink_en;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] seg;

    modport master (
        output mode, text_codes, bin_value, start, lz_blank, blink_en,
        input  busy, done, overflow, seg
    );

    modport slave (
        input  mode, text_codes, bin_value, start, lz_blank, blink_en,
        output busy, done, overflow, seg
    );
endinterface

// File: rtl/seg_display_controller.sv
// Multi-digit seven-segment display controller.
// Shows either a per-digit symbol string (text mode) or a binary value
// converted to decimal by an iterative shift-add-3 engine (number mode),
// with leading-zero blanking, overflow dashes and a free-running blink.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seg_display_if.slave (mode/text/value/start/lz_blank/blink_en in,
//          busy/done/overflow/seg out; seg is active-low {g,f,e,d,c,b,a} per digit)
module seg_display_controller #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BIN_WIDTH  = 26,
    parameter int unsigned BLINK_DIV  = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    seg_display_if.slave bus
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W = 7 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 accept_c;
    logic                 shift_c;
    logic                 fin_c;

    logic [BIN_WIDTH-1:0] bin_sr;
    logic [BCD_W-1:0]     work;
    logic [BCD_W-1:0]     work_adj_c;
    logic                 carry;
    logic [CNT_W-1:0]     shift_cnt;
    logic [BCD_W-1:0]     buffer;
    logic                 overflow_q;
    logic                 busy_q;
    logic                 done_q;

    logic [BLK_W-1:0]     blink_cnt;
    logic                 blink_phase;  // 1 = hidden

    logic [NUM_DIGITS-1:0] keep_c;
    logic                  nz_c;
    logic [SEG_W-1:0]      seg_c;
    logic [SEG_W-1:0]      seg_q;

    // Active-low glyph for a 5-bit symbol code.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = ~7'h3F;
            5'd1:    g = ~7'h06;
            5'd2:    g = ~7'h5B;
            5'd3:    g = ~7'h4F;
            5'd4:    g = ~7'h66;
            5'd5:    g = ~7'h6D;
            5'd6:    g = ~7'h7D;
            5'd7:    g = ~7'h07;
            5'd8:    g = ~7'h7F;
            5'd9:    g = ~7'h6F;
            5'd10:   g = ~7'h77;  // a
            5'd11:   g = ~7'h7C;  // b
            5'd12:   g = ~7'h39;  // c
            5'd13:   g = ~7'h5E;  // d
            5'd14:   g = ~7'h79;  // e
            5'd15:   g = ~7'h71;  // f
            5'd16:   g = ~7'h74;  // h
            5'd17:   g = ~7'h38;  // l
            5'd18:   g = ~7'h10;  // i
            5'd19:   g = ~7'h54;  // n
            5'd20:   g = ~7'h5C;  // o
            5'd21:   g = ~7'h73;  // p
            5'd22:   g = ~7'h50;  // r
            5'd23:   g = ~7'h6D;  // s
            5'd24:   g = ~7'h78;  // t
            5'd25:   g = ~7'h1C;  // u
            5'd26:   g = ~7'h6E;  // y
            5'd28:   g = ~7'h40;  // '-'
            default: g = 7'h7F;   // off
        endcase
        return g;
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Conversion FSM next state and datapath strobes.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        shift_c   = 1'b0;
        fin_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_c  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_c = 1'b1;
                if (shift_cnt == CNT_W'(BIN_WIDTH - 1)) state_nxt = FIN;
            end
            FIN: begin
                fin_c     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add 3 to every BCD digit that is 5 or more before the shift.
    always_comb begin
        work_adj_c = work;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj_c[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    // Shift-add-3 datapath, display buffer and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr     <= '0;
            work       <= '0;
            carry      <= 1'b0;
            shift_cnt  <= '0;
            buffer     <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= fin_c;
            if (accept_c) begin
                bin_sr    <= bus.bin_value;
                work      <= '0;
                carry     <= 1'b0;
                shift_cnt <= '0;
            end else if (shift_c) begin
                bin_sr    <= bin_sr << 1;
                work      <= {work_adj_c[BCD_W-2:0], bin_sr[BIN_WIDTH-1]};
                // Any 1 leaving the top digit means the value needs more digits.
                carry     <= carry | work_adj_c[BCD_W-1];
                shift_cnt <= shift_cnt + CNT_W'(1);
            end
            if (fin_c) begin
                buffer     <= work;
                overflow_q <= carry;
            end
        end
    end

    // Free-running blink divider; phase flips on every wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLK_W'(1);
        end
    end

    // Segment pattern selection; keep_c marks digits at or below the top non-zero digit.
    always_comb begin
        seg_c  = '1;
        nz_c   = 1'b0;
        keep_c = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nz_c      = nz_c | (buffer[4*i +: 4] != 4'd0);
            keep_c[i] = nz_c | (i == 0);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            case (bus.mode)
                2'd1: seg_c[7*i +: 7] = decode(bus.text_codes[5*i +: 5]);
                2'd2: begin
                    if (overflow_q)                    seg_c[7*i +: 7] = decode(5'd28);
                    else if (bus.lz_blank && !keep_c[i]) seg_c[7*i +: 7] = 7'h7F;
                    else                               seg_c[7*i +: 7] = decode({1'b0, buffer[4*i +: 4]});
                end
                default: seg_c[7*i +: 7] = 7'h7F;
            endcase
        end
        if (bus.blink_en && blink_phase) seg_c = '1;
    end

    // Registered segment drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) seg_q <= '1;
        else     seg_q <= seg_c;
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.seg      = seg_q;

endmodule

// File: tb/tb_seg_display_controller.sv
// Bench for seg_display_controller: two instances (8 digits / 26-bit and
// 4 digits / 16-bit, both with a short blink period) checked every cycle
// against a decimal-arithmetic model, plus hand-computed literal expectations.
module tb_seg_display_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seg_display_if #(.NUM_DIGITS(8), .BIN_WIDTH(26)) if_a ();
    seg_display_if #(.NUM_DIGITS(4), .BIN_WIDTH(16)) if_b ();

    seg_display_controller #(.NUM_DIGITS(8), .BIN_WIDTH(26), .BLINK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    seg_display_controller #(.NUM_DIGITS(4), .BIN_WIDTH(16), .BLINK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
    );

    typedef struct {
        int         cnt;     // edges left until the result lands (0 = idle)
        longint     pend;
        longint     shown;
        bit         ovf;
        bit         busy;
        bit         done;
        bit         phase;   // 1 = hidden
        int         bcnt;
        logic [55:0] seg;
    } model_t;

    model_t m_a, m_b;

    // Lit segments of each symbol, by segment letter.
    function automatic string glyph_segs(input int code);
        case (code)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";
            3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
            6: return "acdefg";   7: return "abc";     8: return "abcdefg";
            9: return "abcdfg";   10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";
            15: return "aefg";    16: return "cefg";   17: return "def";
            18: return "e";       19: return "ceg";    20: return "cdeg";
            21: return "abefg";   22: return "eg";     23: return "acdfg";
            24: return "defg";    25: return "cde";    26: return "bcdfg";
            28: return "g";
            default: return "";
        endcase
    endfunction

    function automatic logic [6:0] glyph(input int code);
        string s;
        logic [6:0] g;
        s = glyph_segs(code);
        g = '1;
        for (int j = 0; j < s.len(); j++) g[3'(s[j] - 8'd97)] = 1'b0;
        return g;
    endfunction

    function automatic longint pow10(input int n);
        longint p = 1;
        repeat (n) p = p * 10;
        return p;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.cnt = 0; m.pend = 0; m.shown = 0; m.ovf = 0; m.busy = 0; m.done = 0;
        m.phase = 0; m.bcnt = 0; m.seg = '1;
        return m;
    endfunction

    // One clock edge of the display, computed from pre-edge state and inputs.
    function automatic model_t model_step(input model_t m, input int nd, input int bw, input int bd,
                                          input logic [1:0] mode, input logic [39:0] codes,
                                          input longint val, input bit start, input bit lz,
                                          input bit blink);
        model_t n = m;
        n.seg = '1;
        if (!(blink && m.phase)) begin
            for (int i = 0; i < nd; i++) begin
                if (mode == 2'd1)
                    n.seg[7*i +: 7] = glyph(int'(codes[5*i +: 5]));
                else if (mode == 2'd2) begin
                    if (m.ovf)                                  n.seg[7*i +: 7] = glyph(28);
                    else if (lz && i > 0 && m.shown < pow10(i)) n.seg[7*i +: 7] = '1;
                    else n.seg[7*i +: 7] = glyph(int'((m.shown / pow10(i)) % 10));
                end
            end
        end
        n.done = 0;
        if (m.cnt == 0 && start) begin
            n.cnt  = bw + 1;
            n.pend = val;
        end else if (m.cnt > 0) begin
            n.cnt = m.cnt - 1;
            if (n.cnt == 0) begin
                n.shown = m.pend;
                n.ovf   = m.pend >= pow10(nd);
                n.done  = 1;
            end
        end
        n.busy = n.cnt > 0;
        if (m.bcnt == bd - 1) begin
            n.bcnt  = 0;
            n.phase = !m.phase;
        end else begin
            n.bcnt = m.bcnt + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= model_reset();
            m_b <= model_reset();
        end else begin
            m_a <= model_step(m_a, 8, 26, 4, if_a.mode, 40'(if_a.text_codes), longint'(if_a.bin_value),
                              if_a.start, if_a.lz_blank, if_a.blink_en);
            m_b <= model_step(m_b, 4, 16, 4, if_b.mode, 40'(if_b.text_codes), longint'(if_b.bin_value),
                              if_b.start, if_b.lz_blank, if_b.blink_en);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_busy", 64'(if_a.busy), 64'(m_a.busy));
            check("a_done", 64'(if_a.done), 64'(m_a.done));
            check("a_overflow", 64'(if_a.overflow), 64'(m_a.ovf));
            check("a_seg", 64'(if_a.seg), 64'(m_a.seg[55:0]));
            check("b_busy", 64'(if_b.busy), 64'(m_b.busy));
            check("b_done", 64'(if_b.done), 64'(m_b.done));
            check("b_overflow", 64'(if_b.overflow), 64'(m_b.ovf));
            check("b_seg", 64'(if_b.seg), 64'(m_b.seg[27:0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start a conversion, check the done latency, then wait one edge for seg.
    task automatic convert(input bit on_b, input longint v);
        int lat;
        if (on_b) begin if_b.bin_value = 16'(v); if_b.start = 1'b1; end
        else      begin if_a.bin_value = 26'(v); if_a.start = 1'b1; end
        tick(1);
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        lat = -1;
        for (int j = 1; j <= 60; j++) begin
            tick(1);
            if ((on_b ? if_b.done : if_a.done) === 1'b1) begin
                lat = j;
                break;
            end
        end
        check(on_b ? "b_done_latency" : "a_done_latency", 64'(lat), on_b ? 64'(17) : 64'(27));
        tick(1);
    endtask

    initial begin
        int dones, first_done, hidden;
        if_a.mode = 2'd0; if_a.text_codes = '0; if_a.bin_value = '0;
        if_a.start = 1'b0; if_a.lz_blank = 1'b0; if_a.blink_en = 1'b0;
        if_b.mode = 2'd0; if_b.text_codes = '0; if_b.bin_value = '0;
        if_b.start = 1'b0; if_b.lz_blank = 1'b0; if_b.blink_en = 1'b0;
        rst = 1'b1;
        tick(2);
        chk_en = 1'b1;
        check("rst_seg_a", 64'(if_a.seg), 64'({56{1'b1}}));
        check("rst_busy_a", 64'(if_a.busy), 64'(0));
        rst = 1'b0;

        // Text "rea dy" style string, digit 0 = y.
        if_a.mode = 2'd1;
        if_a.text_codes = {5'd27, 5'd27, 5'd27, 5'd22, 5'd14, 5'd10, 5'd13, 5'd26};
        tick(1);
        check("text_d0_y", 64'(if_a.seg[6:0]), 64'(7'b0010001));
        check("text_d4_r", 64'(if_a.seg[34:28]), 64'(7'b0101111));
        check("text_d7_off", 64'(if_a.seg[55:49]), 64'(7'b1111111));

        // Number mode: 12345678 without blanking.
        if_a.mode = 2'd2;
        convert(1'b0, 12345678);
        check("num_d0_8", 64'(if_a.seg[6:0]), 64'(7'b0000000));
        check("num_d7_1", 64'(if_a.seg[55:49]), 64'(7'b1111001));
        check("num_ovf", 64'(if_a.overflow), 64'(0));

        // Leading-zero blanking.
        if_a.lz_blank = 1'b1;
        convert(1'b0, 40);
        check("lz40_upper", 64'(if_a.seg[55:14]), 64'({42{1'b1}}));
        check("lz40_d1_4", 64'(if_a.seg[13:7]), 64'(7'b0011001));
        check("lz40_d0_0", 64'(if_a.seg[6:0]), 64'(7'b1000000));
        convert(1'b0, 0);
        check("lz0_upper", 64'(if_a.seg[55:7]), 64'({49{1'b1}}));
        check("lz0_d0_0", 64'(if_a.seg[6:0]), 64'(7'b1000000));

        // Four-digit instance: overflow and recovery.
        if_b.mode = 2'd2;
        convert(1'b1, 12345);
        check("b_ovf_set", 64'(if_b.overflow), 64'(1));
        check("b_ovf_dashes", 64'(if_b.seg), 64'({4{7'b0111111}}));
        convert(1'b1, 9999);
        check("b_ovf_clear", 64'(if_b.overflow), 64'(0));
        check("b_9999", 64'(if_b.seg), 64'({4{7'b0010000}}));

        // Start pulses during SHIFT are ignored.
        if_a.bin_value = 26'd777;
        if_a.start = 1'b1;
        tick(1);
        dones = 0;
        first_done = -1;
        for (int j = 1; j <= 40; j++) begin
            if_a.start = (j == 5 || j == 15);
            if_a.bin_value = (j == 5 || j == 15) ? 26'd999 : 26'd777;
            tick(1);
            if (if_a.done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = j;
            end
        end
        if_a.start = 1'b0;
        check("ignore_start_dones", 64'(dones), 64'(1));
        check("ignore_start_latency", 64'(first_done), 64'(27));

        // Reset in the middle of a conversion.
        if_a.bin_value = 26'd55555;
        if_a.start = 1'b1;
        tick(1);
        if_a.start = 1'b0;
        tick(10);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(if_a.busy), 64'(0));
        check("abort_seg", 64'(if_a.seg), 64'({56{1'b1}}));
        tick(2);
        rst = 1'b0;
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            tick(1);
            if (if_a.done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        check("abort_buf_zero", 64'(if_a.seg), 64'({{49{1'b1}}, 7'b1000000}));

        // Blinking on a text pattern.
        if_a.mode = 2'd1;
        if_a.blink_en = 1'b1;
        tick(1);
        hidden = 0;
        for (int j = 0; j < 16; j++) begin
            tick(1);
            if (if_a.seg === {56{1'b1}}) hidden++;
        end
        check("blink_hidden_cycles", 64'(hidden), 64'(8));
        if_a.blink_en = 1'b0;
        tick(1);
        hidden = 0;
        for (int j = 0; j < 8; j++) begin
            tick(1);
            if (if_a.seg === {56{1'b1}}) hidden++;
        end
        check("steady_hidden_cycles", 64'(hidden), 64'(0));

        // Blank modes.
        if_a.mode = 2'd3;
        if_b.mode = 2'd0;
        tick(2);
        check("mode3_blank", 64'(if_a.seg), 64'({56{1'b1}}));
        check("mode0_blank", 64'(if_b.seg), 64'({28{1'b1}}));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
